alu_share_arbiter: RTL and testbench

Arbitrates one combinational RV32I ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch-compare path. Each request port uses a valid/ready handshake. A round-robin grant picks the winner and one output register holds the result, so latency is one cycle. Results return on a single response channel tagged with the requester ID, and the block keeps per-port grant counters for performance monitoring.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_share_arbiter_if.sv | 28 ++
 rtl/ALU.sv | 38 +++
 rtl/alu_share_arbiter.sv | 95 +++++++++
 tb/tb_alu_share_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU opcode encodings and shared typedefs for the shared-ALU arbiter.
package alu_pkg;

  typedef logic [3:0] alu_op_t;
  typedef logic [0:0] alu_req_id_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b1000;
  localparam alu_op_t ALU_SLL  = 4'b0001;
  localparam alu_op_t ALU_SLT  = 4'b0010;
  localparam alu_op_t ALU_SLTU = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_SRL  = 4'b0101;
  localparam alu_op_t ALU_SRA  = 4'b1101;
  localparam alu_op_t ALU_OR   = 4'b0110;
  localparam alu_op_t ALU_AND  = 4'b0111;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two-port request bus plus tagged response channel of the shared ALU.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  alu_op_t [1:0]         req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  alu_req_id_t           rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/ALU.sv
// Combinational RV32I integer ALU; undefined opcodes produce zero.
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  alu_op_t          ALUOp,
  output logic [WIDTH-1:0] ALURes
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [4:0]              shamt;

  assign a_s   = A;
  assign b_s   = B;
  assign shamt = B[4:0];

  always_comb begin
    ALURes = '0;
    case (ALUOp)
      ALU_ADD:  ALURes = A + B;
      ALU_SUB:  ALURes = A - B;
      ALU_SLL:  ALURes = A << shamt;
      ALU_SLT:  ALURes = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: ALURes = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_XOR:  ALURes = A ^ B;
      ALU_SRL:  ALURes = A >> shamt;
      ALU_SRA:  ALURes = a_s >>> shamt;
      ALU_OR:   ALURes = A | B;
      ALU_AND:  ALURes = A & B;
      default:  ALURes = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters, one registered
// result slot tagged with the winning port, saturating per-port grant counters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]    grant_cnt0,
  output logic [CNT_W-1:0]    grant_cnt1
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             can_accept;
  logic             gnt_vld;
  logic             hs;
  alu_req_id_t      gnt_id;
  alu_req_id_t      prio;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] alu_res;

  logic             rsp_valid_p1;
  logic [WIDTH-1:0] rsp_data_p1;
  alu_req_id_t      rsp_id_p1;
  logic [CNT_W-1:0] cnt0_p1;
  logic [CNT_W-1:0] cnt1_p1;

  // Stage 0: arbitration, handshake and operand mux into the ALU
  always_comb begin
    can_accept    = !rsp_valid_p1 || bus.rsp_ready;
    gnt_vld       = 1'b0;
    gnt_id        = '0;
    if (&bus.req_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = prio;
    end else if (bus.req_valid[0]) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (bus.req_valid[1]) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
    // rst_n gates ready so nothing is accepted in a reset cycle
    hs            = gnt_vld && can_accept && rst_n;
    bus.req_ready = '0;
    if (hs) bus.req_ready[gnt_id] = 1'b1;
  end

  assign alu_a  = bus.req_a[gnt_id];
  assign alu_b  = bus.req_b[gnt_id];
  assign alu_op = bus.req_op[gnt_id];

  ALU #(.WIDTH(WIDTH)) u_alu (
    .A      (alu_a),
    .B      (alu_b),
    .ALUOp  (alu_op),
    .ALURes (alu_res)
  );

  // Stage 1: result register, rotation pointer, grant counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_p1 <= 1'b0;
      rsp_data_p1  <= '0;
      rsp_id_p1    <= '0;
      prio         <= '0;
      cnt0_p1      <= '0;
      cnt1_p1      <= '0;
    end else if (hs) begin
      rsp_valid_p1 <= 1'b1;
      rsp_data_p1  <= alu_res;
      rsp_id_p1    <= gnt_id;
      prio         <= ~gnt_id;
      if (gnt_id == 1'b0) cnt0_p1 <= sat_inc(cnt0_p1);
      else                cnt1_p1 <= sat_inc(cnt1_p1);
    end else if (bus.rsp_ready && rsp_valid_p1) begin
      rsp_valid_p1 <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_id    = rsp_id_p1;
  assign grant_cnt0    = cnt0_p1;
  assign grant_cnt1    = cnt1_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (4-bit counters so saturation is reachable).
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
  int               n_chk  = 0;
  int               n_pass = 0;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input alu_op_t op);
    bus.req_valid[p] = v;
    bus.req_a[p]     = a;
    bus.req_b[p]     = b;
    bus.req_op[p]    = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1] = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2] = '{ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    vecs[3] = '{ALU_SLTU, 32'hFFFF_FFFB, 32'h0000_0005, 32'h0000_0000};
    vecs[4] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[5] = '{ALU_OR,   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
    vecs[6] = '{4'b1111,  32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
    vecs[7] = '{ALU_SLT,  32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000};

    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // reset state; ready must stay low while in reset even with valids high
    @(negedge clk);
    chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
    tick();
    tick();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_cnt0", 32'(grant_cnt0), 32'h0);
    chk("rst_cnt1", 32'(grant_cnt1), 32'h0);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;

    // single request
    set_req(0, 1'b1, 32'd10, 32'd5, ALU_ADD);
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    chk("single_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_data", bus.rsp_data, 32'd15);
    chk("single_id", 32'(bus.rsp_id), 32'h0);
    chk("single_cnt0", 32'(grant_cnt0), 32'h1);

    // both ports contending every cycle: strict alternation starting at port 0
    do_reset();
    set_req(0, 1'b1, 32'd10, 32'd5, ALU_SUB);
    set_req(1, 1'b1, 32'hFFFF_FFFB, 32'd5, ALU_SLT);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("rr_data", bus.rsp_data, (i % 2 == 0) ? 32'd5 : 32'd1);
      chk("rr_id", 32'(bus.rsp_id), 32'(i % 2));
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    chk("rr_cnt0", 32'(grant_cnt0), 32'd2);
    chk("rr_cnt1", 32'(grant_cnt1), 32'd2);

    // backpressure holds the result and blocks both ports
    do_reset();
    set_req(1, 1'b1, 32'hFFFF_FFF8, 32'd2, ALU_SRA);
    @(negedge clk);
    chk("bp_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    set_req(0, 1'b1, 32'd10, 32'd5, ALU_ADD);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready_blocked", 32'(bus.req_ready), 32'h0);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_hold_data", bus.rsp_data, 32'hFFFF_FFFE);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'h1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    chk("bp_after_data", bus.rsp_data, 32'd15);
    chk("bp_after_id", 32'(bus.rsp_id), 32'h0);

    // back-to-back on port 1; DEADBEEF & 12345678 = 12241668
    set_req(1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, ALU_AND);
    @(negedge clk);
    chk("b2b_ready_and", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, ALU_XOR);
    chk("b2b_and", bus.rsp_data, 32'h1224_1668);
    chk("b2b_prio_and", 32'(dut.prio), 32'h0);
    @(negedge clk);
    chk("b2b_ready_xor", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    chk("b2b_xor", bus.rsp_data, 32'hCC99_E897);
    chk("b2b_id", 32'(bus.rsp_id), 32'h1);
    chk("b2b_prio_xor", 32'(dut.prio), 32'h0);

    // ALU opcode table through port 0, one op per cycle
    do_reset();
    foreach (vecs[i]) begin
      set_req(0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      tick();
      chk($sformatf("alu_vec%0d", i), bus.rsp_data, vecs[i].exp);
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);

    // reset while a result is held and a new request is pending
    do_reset();
    set_req(1, 1'b1, 32'd1, 32'd2, ALU_ADD);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    set_req(0, 1'b1, 32'd7, 32'd7, ALU_ADD);
    @(negedge clk);
    chk("mid_pre_valid", 32'(bus.rsp_valid), 32'h1);
    chk("mid_pre_ready", 32'(bus.req_ready), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_cnt0", 32'(grant_cnt0), 32'h0);
    chk("mid_cnt1", 32'(grant_cnt1), 32'h0);
    chk("mid_prio", 32'(dut.prio), 32'h0);
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    rst_n = 1'b1;
    tick();
    chk("mid_no_stale", 32'(bus.rsp_valid), 32'h0);

    // counter saturation
    do_reset();
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_reach15", 32'(grant_cnt0), 32'd15);
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    chk("sat_cnt0", 32'(grant_cnt0), 32'd15);
    chk("sat_cnt1", 32'(grant_cnt1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
